regfile_access_arb: RTL

REGFILE_ACCESS_ARB -- requirements
Module: regfile_access_arb

---
 rtl/regfile_access_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_access_arb.sv
// regfile_access_arb: round-robin arbiter for two requesters onto one regfile port pair.
// Optional REGFILE_ARB_ERR_EN: out-of-range addresses complete with mN_resp_err.
module regfile_access_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 10,
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_valid,
  input  logic                    m0_req_write,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_req_be,
  output logic                    m0_req_ready,
  output logic                    m0_resp_valid,
  output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
  input  logic                    m1_req_valid,
  input  logic                    m1_req_write,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_req_be,
  output logic                    m1_req_ready,
  output logic                    m1_resp_valid,
  output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
`ifdef REGFILE_ARB_ERR_EN
  output logic                    m0_resp_err,
  output logic                    m1_resp_err,
`endif
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [DATA_WIDTH/8-1:0] rf_wr_be,
  output logic [ADDR_WIDTH-1:0]   rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data
);

  localparam int BW = DATA_WIDTH/8;
`ifdef REGFILE_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic                  last_gnt;
  logic                  gnt_vld;
  logic                  gnt_id;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BW-1:0]         sel_be;
  logic                  sel_skip;

  logic                  r_id;
  logic                  r_wr;
  logic                  r_skip;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BW-1:0]         r_be;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  do_acc;
  logic                  do_rd;
  logic                  resp;

  // Tie goes to whoever was not granted last; no grant while in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE && rst_n) begin
      unique case (1'b1)
        m0_req_valid && m1_req_valid: begin
          gnt_vld = 1'b1;
          gnt_id  = ~last_gnt;
        end
        m0_req_valid && !m1_req_valid: begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
        !m0_req_valid && m1_req_valid: begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_wr    = gnt_id ? m1_req_write : m0_req_write;
    sel_addr  = gnt_id ? m1_req_addr  : m0_req_addr;
    sel_wdata = gnt_id ? m1_req_wdata : m0_req_wdata;
    sel_be    = gnt_id ? m1_req_be    : m0_req_be;
    sel_skip  = ERR_EN && (32'(sel_addr) >= NUM_REGS);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      r_id     <= 1'b0;
      r_wr     <= 1'b0;
      r_skip   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        last_gnt <= gnt_id;
        r_id     <= gnt_id;
        r_wr     <= sel_wr;
        r_skip   <= sel_skip;
        r_addr   <= sel_addr;
        r_wdata  <= sel_wdata;
        r_be     <= sel_be;
      end
      if (state == ACCESS)
        r_rdata <= do_rd ? rf_rd_data : '0;
    end
  end

  assign do_acc = (state == ACCESS) && !r_skip;
  assign do_rd  = do_acc && !r_wr;

  assign rf_wr_en   = do_acc && r_wr;
  assign rf_wr_addr = r_addr;
  assign rf_wr_data = r_wdata;
  assign rf_wr_be   = r_be;
  assign rf_rd_addr = do_rd ? r_addr : PARK_ADDR;

  assign m0_req_ready = gnt_vld && !gnt_id;
  assign m1_req_ready = gnt_vld && gnt_id;

  assign resp          = (state == RESP) && rst_n;
  assign m0_resp_valid = resp && !r_id;
  assign m1_resp_valid = resp && r_id;
  assign m0_resp_rdata = m0_resp_valid ? r_rdata : '0;
  assign m1_resp_rdata = m1_resp_valid ? r_rdata : '0;

`ifdef REGFILE_ARB_ERR_EN
  assign m0_resp_err = m0_resp_valid && r_skip;
  assign m1_resp_err = m1_resp_valid && r_skip;
`endif

endmodule
